// File: rtl/cacheline_pkg.sv
// Shared widths, types and helpers for the cacheline adapter.
// Optional feature macro: CLADAPT_RESP_REG_EN (registered read response).
package cacheline_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic {CLA_IDLE, CLA_WRITE} cla_state_t;
    typedef logic [LINE_W-1:0] cacheline_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/cacheline_deserializer.sv
// Collects 4 contiguous read beats into one line and emits it with its address.
// CLADAPT_RESP_REG_EN: registered output (+1 cycle), else combinational.
module cacheline_deserializer
    import cacheline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_valid,
    input  logic [ADDR_W-1:0] beat_addr,
    input  logic [BEAT_W-1:0] beat_data,
    output logic              line_valid,
    output logic [ADDR_W-1:0] line_addr,
    output cacheline_t        line_data
);
    logic [CNT_W-1:0]         rcnt;
    logic [LINE_W-BEAT_W-1:0] buf_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     last;

    assign last = beat_valid && (rcnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt   <= '0;
            buf_q  <= '0;
            addr_q <= '0;
        end else if (beat_valid) begin
            rcnt <= rcnt + 1'b1;
            if (rcnt == '0)
                addr_q <= beat_addr;
            // the final beat bypasses the buffer straight into the line
            if (!last)
                buf_q[rcnt*BEAT_W +: BEAT_W] <= beat_data;
        end
    end

`ifdef CLADAPT_RESP_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= 1'b0;
            line_addr  <= '0;
            line_data  <= '0;
        end else begin
            line_valid <= last;
            if (last) begin
                line_addr <= addr_q;
                line_data <= {beat_data, buf_q};
            end
        end
    end
`else
    assign line_valid = last;
    assign line_addr  = addr_q;
    assign line_data  = {beat_data, buf_q};
`endif

    // a burst, once started, must deliver its beats back to back
    always @(posedge clk) begin
        if (!rst && rcnt != '0)
            assert (beat_valid);
    end
endmodule

// File: rtl/cacheline_adapter.sv
// Splits 256-bit line requests into 4x64-bit memory bursts and reassembles reads.
// CLADAPT_RESP_REG_EN selects a registered read response path.
module cacheline_adapter
    import cacheline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  cacheline_t        dfp_wdata,
    output logic              dfp_ready,
    output logic [ADDR_W-1:0] dfp_raddr,
    output cacheline_t        dfp_rdata,
    output logic              dfp_rvalid,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);
    cla_state_t        state;
    cacheline_t        line_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  wcnt;
    logic              idle;
    logic              wr_acc;
    logic              rd_acc;

    assign idle      = (state == CLA_IDLE);
    assign dfp_ready = !rst && idle && bmem_ready;
    // write wins if both are raised; that case is illegal anyway
    assign wr_acc    = dfp_ready && dfp_write;
    assign rd_acc    = dfp_ready && dfp_read && !dfp_write;

    assign bmem_read  = rd_acc;
    assign bmem_addr  = rd_acc ? line_align(dfp_addr) : addr_q;
    assign bmem_write = !idle;
    assign bmem_wdata = idle ? '0 : line_q[wcnt*BEAT_W +: BEAT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CLA_IDLE;
            line_q <= '0;
            addr_q <= '0;
            wcnt   <= '0;
        end else begin
            unique case (state)
                CLA_IDLE: begin
                    if (wr_acc) begin
                        line_q <= dfp_wdata;
                        addr_q <= line_align(dfp_addr);
                        wcnt   <= '0;
                        state  <= CLA_WRITE;
                    end
                end
                CLA_WRITE: begin
                    if (bmem_ready) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == CNT_W'(BEATS - 1))
                            state <= CLA_IDLE;
                    end
                end
                default: state <= CLA_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst)
            assert (!(dfp_ready && dfp_read && dfp_write));
    end

    cacheline_deserializer u_deser (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (bmem_rvalid),
        .beat_addr  (bmem_raddr),
        .beat_data  (bmem_rdata),
        .line_valid (dfp_rvalid),
        .line_addr  (dfp_raddr),
        .line_data  (dfp_rdata)
    );
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter.
// Honours CLADAPT_RESP_REG_EN for the read response latency.
module tb_cacheline_adapter;
    import cacheline_pkg::*;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    cacheline_t        dfp_wdata;
    logic              dfp_ready;
    logic [ADDR_W-1:0] dfp_raddr;
    cacheline_t        dfp_rdata;
    logic              dfp_rvalid;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CLADAPT_RESP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic [63:0] wd [4];
    logic [63:0] rb [8];
    logic [31:0] ra [2];

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_ready   (dfp_ready),
        .dfp_raddr   (dfp_raddr),
        .dfp_rdata   (dfp_rdata),
        .dfp_rvalid  (dfp_rvalid),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input bit stall);
        int sb [7] = '{0, 1, 2, 2, 2, 2, 3};
        bit sr [7] = '{1, 1, 0, 0, 0, 1, 1};
        int n;
        int e;
        n = stall ? 7 : 4;
        @(negedge clk);
        dfp_addr  = 32'h0000_0100;
        dfp_wdata = {wd[3], wd[2], wd[1], wd[0]};
        dfp_write = 1'b1;
        bmem_ready = 1'b1;
        #1 chk("wr_accept_ready", 256'(dfp_ready), 256'(1));
        @(negedge clk);
        dfp_write = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            bmem_ready = stall ? sr[k] : 1'b1;
            e = stall ? sb[k] : k;
            #1;
            chk($sformatf("wr_data_c%0d", k), 256'(bmem_wdata), 256'(wd[e]));
            chk($sformatf("wr_valid_c%0d", k), 256'(bmem_write), 256'(1));
            chk($sformatf("wr_busy_c%0d", k), 256'(dfp_ready), 256'(0));
            chk($sformatf("wr_addr_c%0d", k), 256'(bmem_addr), 256'(32'h100));
        end
        @(negedge clk);
        bmem_ready = 1'b1;
        #1;
        chk("wr_done_ready", 256'(dfp_ready), 256'(1));
        chk("wr_done_write", 256'(bmem_write), 256'(0));
    endtask

    task automatic run_resp(input int nb);
        int j;
        bit pulse;
        for (int k = 0; k < nb * 4 + 2; k++) begin
            @(negedge clk);
            if (k < nb * 4) begin
                bmem_rvalid = 1'b1;
                bmem_rdata  = rb[k];
                bmem_raddr  = ra[k / 4];
            end else begin
                bmem_rvalid = 1'b0;
                bmem_rdata  = '0;
                bmem_raddr  = '0;
            end
            #1;
            j = k - LAT;
            pulse = (j >= 0) && (j % 4 == 3) && (j / 4 < nb);
            chk($sformatf("rsp_valid_c%0d", k), 256'(dfp_rvalid), 256'(pulse));
            if (pulse) begin
                chk($sformatf("rsp_data_c%0d", k), dfp_rdata,
                    {rb[j-0], rb[j-1], rb[j-2], rb[j-3]});
                chk($sformatf("rsp_addr_c%0d", k), 256'(dfp_raddr), 256'(ra[j / 4]));
            end
        end
    endtask

    initial begin
        wd[0] = 64'h0D0D_0000_0000_0000;
        wd[1] = 64'h1D1D_1111_1111_1111;
        wd[2] = 64'h2D2D_2222_2222_2222;
        wd[3] = 64'h3D3D_3333_3333_3333;
        rst = 1'b1;
        dfp_addr = '0;
        dfp_read = 1'b0;
        dfp_write = 1'b0;
        dfp_wdata = '0;
        bmem_ready = 1'b1;
        bmem_raddr = '0;
        bmem_rdata = '0;
        bmem_rvalid = 1'b0;

        #3;
        chk("rst_ready", 256'(dfp_ready), 256'(0));
        chk("rst_rvalid", 256'(dfp_rvalid), 256'(0));
        chk("rst_bread", 256'(bmem_read), 256'(0));
        chk("rst_bwrite", 256'(bmem_write), 256'(0));
        chk("rst_baddr", 256'(bmem_addr), 256'(0));
        chk("rst_bwdata", 256'(bmem_wdata), 256'(0));
        chk("rst_rdata", dfp_rdata, 256'(0));
        chk("rst_raddr", 256'(dfp_raddr), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", 256'(dfp_ready), 256'(1));

        // read pass-through
        @(negedge clk);
        dfp_addr = 32'h1234_5678;
        dfp_read = 1'b1;
        #1;
        chk("rd_bread", 256'(bmem_read), 256'(1));
        chk("rd_baddr", 256'(bmem_addr), 256'(32'h1234_5660));
        chk("rd_bwrite", 256'(bmem_write), 256'(0));
        @(negedge clk);
        dfp_read = 1'b0;
        #1 chk("rd_bread_off", 256'(bmem_read), 256'(0));

        do_write(1'b0);
        do_write(1'b1);

        // single response burst
        rb[0] = 64'hAAAA_0000_AAAA_0000;
        rb[1] = 64'hBBBB_1111_BBBB_1111;
        rb[2] = 64'hCCCC_2222_CCCC_2222;
        rb[3] = 64'hDDDD_3333_DDDD_3333;
        ra[0] = 32'h0000_0200;
        run_resp(1);

        // two reads back-to-back, then two bursts back-to-back
        @(negedge clk);
        dfp_addr = 32'h0000_041C;
        dfp_read = 1'b1;
        #1;
        chk("rd2a_bread", 256'(bmem_read), 256'(1));
        chk("rd2a_baddr", 256'(bmem_addr), 256'(32'h400));
        @(negedge clk);
        dfp_addr = 32'h0000_0447;
        #1;
        chk("rd2b_bread", 256'(bmem_read), 256'(1));
        chk("rd2b_baddr", 256'(bmem_addr), 256'(32'h440));
        @(negedge clk);
        dfp_read = 1'b0;
        for (int i = 0; i < 8; i++)
            rb[i] = {32'hF00D_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 3)};
        ra[0] = 32'h0000_0400;
        ra[1] = 32'h0000_0440;
        run_resp(2);

        // reset in the middle of a burst
        @(negedge clk);
        bmem_rvalid = 1'b1;
        bmem_raddr = 32'h0000_0DEA;
        bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        bmem_rdata = 64'hBEEF_BEEF_BEEF_BEEF;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_rdata = '0;
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", 256'(dfp_rvalid), 256'(0));
        chk("midrst_rdata", dfp_rdata, 256'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_ready", 256'(dfp_ready), 256'(1));
        rb[0] = 64'h1111_2222_3333_4444;
        rb[1] = 64'h5555_6666_7777_8888;
        rb[2] = 64'h9999_AAAA_BBBB_CCCC;
        rb[3] = 64'hDDDD_EEEE_FFFF_0001;
        ra[0] = 32'h0000_0600;
        run_resp(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
